// File: rtl/alu_pipe_if.sv
// Valid/ready operation and result bundle for alu_pipe.
// master drives operations and accepts results; slave is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             sn;
    logic             ZR;
    logic             carry;
    logic             P;
    logic             V;
    logic             cf;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, s, sn, ZR, carry, P, V, cf
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, s, sn, ZR, carry, P, V, cf
    );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined WIDTH-bit ALU: the full result and flags are formed at acceptance,
// later stages only delay them. cf chains multi-word ADC/SBB sequences.
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    alu_pipe_if.slave bus
);
    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_ADC   = 3'd1,
        OP_SUB   = 3'd2,
        OP_SBB   = 3'd3,
        OP_AND   = 3'd4,
        OP_OR    = 3'd5,
        OP_XOR   = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             sn;
        logic             zr;
        logic             carry;
        logic             p;
        logic             v;
    } res_t;

    op_e               op;
    logic              arith;
    logic              cin;
    logic [WIDTH:0]    wide;
    res_t              res;
    res_t              pipe [STAGES];
    logic [STAGES-1:0] vld;
    logic              stall;
    logic              accept;
    logic              cf_q;

    assign op    = op_e'(bus.op);
    assign arith = (op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBB});

    // Bit WIDTH of the extended sum/difference is carry-out or borrow; zero for logic ops.
    always_comb begin
        cin   = 1'b0;
        wide  = '0;
        res   = '0;
        unique case (op)
            OP_ADD, OP_ADC: begin
                cin   = (op == OP_ADC) & cf_q;
                wide  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
                res.v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (wide[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                cin   = (op == OP_SBB) & cf_q;
                wide  = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, cin};
                res.v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (wide[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:   wide = {1'b0, bus.a & bus.b};
            OP_OR:    wide = {1'b0, bus.a | bus.b};
            OP_XOR:   wide = {1'b0, bus.a ^ bus.b};
            OP_PASSB: wide = {1'b0, bus.b};
        endcase
        res.s     = wide[WIDTH-1:0];
        res.carry = wide[WIDTH];
        res.sn    = wide[WIDTH-1];
        res.zr    = ~|wide[WIDTH-1:0];
        res.p     = ~^wide[WIDTH-1:0];
    end

    assign stall  = vld[STAGES-1] & ~bus.out_ready;
    assign accept = bus.in_valid & ~stall & ~flush;

    // Stage data only loads behind a valid entry, so outputs keep their last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            cf_q <= 1'b0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (accept && arith) begin
                cf_q <= res.carry;
            end
            if (flush) begin
                vld <= '0;
            end else if (!stall) begin
                vld[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    pipe[0] <= res;
                end
                for (int unsigned i = 1; i < STAGES; i++) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = vld[STAGES-1];
    assign bus.s         = pipe[STAGES-1].s;
    assign bus.sn        = pipe[STAGES-1].sn;
    assign bus.ZR        = pipe[STAGES-1].zr;
    assign bus.carry     = pipe[STAGES-1].carry;
    assign bus.P         = pipe[STAGES-1].p;
    assign bus.V         = pipe[STAGES-1].v;
    assign bus.cf        = cf_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: three configurations driven from one stimulus stream,
// each checked every cycle against an arithmetic reference with timed queues.
module tb_alu_pipe;
    localparam logic [2:0] ADD = 3'd0, ADC = 3'd1, SUB = 3'd2, SBB = 3'd3;
    localparam logic [2:0] LAND = 3'd4, LOR = 3'd5, LXOR = 3'd6, PASSB = 3'd7;
    localparam int W  [3] = '{16, 8, 8};
    localparam int ST [3] = '{2, 1, 4};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        drv_valid = 1'b0;
    logic [2:0]  drv_op = '0;
    logic [15:0] drv_a = '0;
    logic [15:0] drv_b = '0;
    logic        drv_ordy = 1'b1;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(16)) i16 ();
    alu_pipe_if #(.WIDTH(8))  i8a ();
    alu_pipe_if #(.WIDTH(8))  i8b ();

    alu_pipe #(.WIDTH(16), .STAGES(2)) u16 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(i16));
    alu_pipe #(.WIDTH(8),  .STAGES(1)) u8a (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(i8a));
    alu_pipe #(.WIDTH(8),  .STAGES(4)) u8b (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(i8b));

    assign i16.in_valid = drv_valid;  assign i16.op = drv_op;
    assign i16.a = drv_a;             assign i16.b = drv_b;        assign i16.out_ready = drv_ordy;
    assign i8a.in_valid = drv_valid;  assign i8a.op = drv_op;
    assign i8a.a = drv_a[7:0];        assign i8a.b = drv_b[7:0];   assign i8a.out_ready = drv_ordy;
    assign i8b.in_valid = drv_valid;  assign i8b.op = drv_op;
    assign i8b.a = drv_a[7:0];        assign i8b.b = drv_b[7:0];   assign i8b.out_ready = drv_ordy;

    logic        o_vld [3];
    logic        o_rdy [3];
    logic [15:0] o_s   [3];
    logic [4:0]  o_fl  [3];   // {sn, ZR, carry, P, V}
    logic        o_cf  [3];

    assign o_vld[0] = i16.out_valid; assign o_rdy[0] = i16.in_ready; assign o_s[0] = i16.s;
    assign o_vld[1] = i8a.out_valid; assign o_rdy[1] = i8a.in_ready; assign o_s[1] = {8'h00, i8a.s};
    assign o_vld[2] = i8b.out_valid; assign o_rdy[2] = i8b.in_ready; assign o_s[2] = {8'h00, i8b.s};
    assign o_fl[0] = {i16.sn, i16.ZR, i16.carry, i16.P, i16.V}; assign o_cf[0] = i16.cf;
    assign o_fl[1] = {i8a.sn, i8a.ZR, i8a.carry, i8a.P, i8a.V}; assign o_cf[1] = i8a.cf;
    assign o_fl[2] = {i8b.sn, i8b.ZR, i8b.carry, i8b.P, i8b.V}; assign o_cf[2] = i8b.cf;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] s;
        logic [4:0]  fl;
    } res_t;

    // Reference: plain integer arithmetic, overflow from the signed result range.
    function automatic res_t model(input int w, input logic [2:0] op,
                                   input logic [15:0] a_in, input logic [15:0] b_in, input logic cf_in);
        int   mask = (1 << w) - 1;
        int   half = 1 << (w - 1);
        int   a = int'(a_in) & mask;
        int   b = int'(b_in) & mask;
        int   ci = ((op == ADC || op == SBB) && cf_in) ? 1 : 0;
        int   sa = (a >= half) ? a - 2 * half : a;
        int   sb = (b >= half) ? b - 2 * half : b;
        int   r = 0;
        int   sr = 0;
        logic c = 1'b0;
        res_t e;
        case (op)
            ADD, ADC: begin r = a + b + ci; c = (r > mask); sr = sa + sb + ci; end
            SUB, SBB: begin r = a - b - ci; c = ((b + ci) > a); sr = sa - sb - ci; end
            LAND:     r = a & b;
            LOR:      r = a | b;
            LXOR:     r = a ^ b;
            default:  r = b;
        endcase
        r = r & mask;
        e.s  = r[15:0];
        e.fl = {r >= half, r == 0, c, ($countones(r) % 2) == 0, (sr >= half) || (sr < -half)};
        return e;
    endfunction

    res_t mq   [3][8];
    int   mrem [3][8];
    int   mcnt [3] = '{0, 0, 0};
    logic mcf  [3] = '{1'b0, 1'b0, 1'b0};

    // Each entry counts unstalled edges left until it reaches the outputs.
    always @(negedge clk) begin
        logic ev;
        logic stl;
        res_t e;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                chk("rst_out_valid", d, o_vld[d], 0);
                chk("rst_result", d, {o_s[d], o_fl[d], o_cf[d]}, 0);
                chk("rst_in_ready", d, o_rdy[d], 1);
                mcnt[d] = 0;
                mcf[d]  = 1'b0;
            end else begin
                ev = (mcnt[d] > 0) && (mrem[d][0] == 0);
                chk("out_valid", d, o_vld[d], ev);
                chk("in_ready", d, o_rdy[d], !(ev && !drv_ordy));
                chk("cf", d, o_cf[d], mcf[d]);
                if (ev) begin
                    chk("s", d, o_s[d], mq[d][0].s);
                    chk("flags", d, o_fl[d], mq[d][0].fl);
                end
                stl = ev && !drv_ordy;
                if (!stl) begin
                    if (ev) begin
                        for (int k = 1; k < mcnt[d]; k++) begin
                            mq[d][k-1]   = mq[d][k];
                            mrem[d][k-1] = mrem[d][k];
                        end
                        mcnt[d]--;
                    end
                    for (int k = 0; k < mcnt[d]; k++) begin
                        if (mrem[d][k] > 0) mrem[d][k]--;
                    end
                end
                if (flush) begin
                    mcnt[d] = 0;
                end else if (drv_valid && !stl && mcnt[d] < 8) begin
                    e = model(W[d], drv_op, drv_a, drv_b, mcf[d]);
                    mq[d][mcnt[d]]   = e;
                    mrem[d][mcnt[d]] = ST[d] - 1;
                    mcnt[d]++;
                    if (drv_op < 3'd4) mcf[d] = e.fl[2];
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        drv_valid = 1'b1; drv_op = o; drv_a = x; drv_b = y;
        cyc();
        drv_valid = 1'b0;
    endtask

    // Holds the operation until the 16-bit instance takes it, with a bounded wait.
    task automatic send16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        logic ok;
        ok = 1'b0;
        drv_valid = 1'b1; drv_op = o; drv_a = x; drv_b = y;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            ok = i16.in_ready;
            @(posedge clk);
            #1;
        end
        drv_valid = 1'b0;
        chk("accept_within_budget", 0, ok, 1);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hffff;
            2:       return 16'h8000;
            3:       return 16'h7fff;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;

        // 8fff + 8000: carry out and signed overflow
        issue(ADD, 16'h8fff, 16'h8000);
        chk("lat1_valid", 1, i8a.out_valid, 1);
        chk("lat2_not_yet", 0, i16.out_valid, 0);
        cyc();
        chk("v1_s", 0, i16.s, 16'h0fff);
        chk("v1_flags", 0, o_fl[0], 5'b00111);
        chk("v1_cf", 0, i16.cf, 1);
        cyc(); cyc();
        chk("lat4_valid", 2, i8b.out_valid, 1);
        chk("lat4_s", 2, i8b.s, 8'hff);

        // wrap to zero then ADC chained on its carry
        issue(ADD, 16'hfffe, 16'h0002);
        issue(ADC, 16'h0001, 16'h0001);
        chk("v2a_s", 0, i16.s, 16'h0000);
        chk("v2a_flags", 0, o_fl[0], 5'b01110);
        cyc();
        chk("v2b_s", 0, i16.s, 16'h0003);
        chk("v2b_flags", 0, o_fl[0], 5'b00010);
        chk("v2b_cf", 0, i16.cf, 0);

        issue(ADD, 16'haaaa, 16'h5555);
        issue(SUB, 16'h8000, 16'h0001);
        chk("v3a_s", 0, i16.s, 16'hffff);
        chk("v3a_flags", 0, o_fl[0], 5'b10010);
        issue(SUB, 16'h0000, 16'h0001);
        chk("v3b_s", 0, i16.s, 16'h7fff);
        chk("v3b_flags", 0, o_fl[0], 5'b00001);
        cyc();
        chk("v3c_s", 0, i16.s, 16'hffff);
        chk("v3c_flags", 0, o_fl[0], 5'b10110);

        // logic op leaves cf at 1
        issue(LXOR, 16'hf0f0, 16'hf0f0);
        cyc();
        chk("xor_s", 0, i16.s, 16'h0000);
        chk("xor_flags", 0, o_fl[0], 5'b01010);
        chk("xor_cf", 0, i16.cf, 1);

        // clear cf, then a borrowing SUB offered with flush must not touch it
        issue(ADD, 16'h0000, 16'h0000);
        flush = 1'b1; drv_valid = 1'b1; drv_op = SUB; drv_a = 16'h0000; drv_b = 16'h0001;
        cyc();
        flush = 1'b0; drv_valid = 1'b0;
        chk("flush_cf", 0, i16.cf, 0);
        chk("flush_valid", 0, i16.out_valid, 0);
        cyc();
        chk("flush_valid_later", 0, i16.out_valid, 0);
        chk("flush_valid_s4", 2, i8b.out_valid, 0);

        // stall mid-stream
        send16(ADD, 16'h0001, 16'h0002);
        send16(ADD, 16'h0003, 16'h0004);
        drv_ordy = 1'b0;
        drv_valid = 1'b1; drv_op = ADD; drv_a = 16'h0005; drv_b = 16'h0006;
        repeat (3) begin
            #1;
            chk("stall_in_ready", 0, i16.in_ready, 0);
            chk("stall_out_valid", 0, i16.out_valid, 1);
            chk("stall_s", 0, i16.s, 16'h0003);
            @(posedge clk);
            #1;
        end
        drv_ordy = 1'b1;
        send16(ADD, 16'h0005, 16'h0006);
        send16(ADD, 16'h0007, 16'h0008);
        chk("stream_3", 0, i16.s, 16'h000b);
        cyc();
        chk("stream_4", 0, i16.s, 16'h000f);

        // randomized traffic with backpressure and occasional flush
        repeat (400) begin
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_op    = 3'($urandom_range(0, 7));
            drv_a     = pick();
            drv_b     = pick();
            drv_ordy  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            cyc();
        end
        flush = 1'b0; drv_ordy = 1'b1;

        // reset with operations in flight
        issue(ADD, 16'h1234, 16'h4321);
        issue(SUB, 16'h0000, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("midrst_valid", d, o_vld[d], 0);
            chk("midrst_flags", d, {o_s[d], o_fl[d]}, 0);
            chk("midrst_cf", d, o_cf[d], 0);
        end
        cyc();
        rst_n = 1'b1;

        drv_valid = 1'b0;
        repeat (8) cyc();
        for (int d = 0; d < 3; d++) chk("drained", d, o_vld[d], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor to the 16-bit combinational adder/ALU. It performs WIDTH-bit add/subtract with and without carry, plus bitwise logic ops. It produces the same flag set as the 16-bit block (sign, zero, carry, parity, overflow) and keeps an architectural carry register for multi-word chaining. It sits in the datapath behind a valid/ready handshake, with a configurable pipeline depth for timing closure.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)
STAGES, 2, pipeline register stages (1..4); total latency in cycles

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous; invalidates all in-flight entries
in_valid  input  1  operation offered
in_ready  output  1  operation accepted when in_valid & in_ready
op  input  3  0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 AND, 5 OR, 6 XOR, 7 PASSB
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
s  output  WIDTH  result
sn  output  1  sign = s[WIDTH-1]
ZR  output  1  1 when s == 0
carry  output  1  carry-out (add) or borrow (sub); 0 for logic ops
P  output  1  even parity: 1 when popcount(s) is even
V  output  1  signed overflow; 0 for logic ops
cf  output  1  architectural carry register

Behaviour:
- Reset (rst_n low, async): all stage valids 0, out_valid 0, s/sn/ZR/carry/P/V 0, cf 0. in_ready is 1 after reset release.
- Arithmetic is computed entirely at acceptance, in stage 1. Later stages only delay, so there is no data hazard.
- ADD: s = a+b, carry = bit WIDTH of the (WIDTH+1)-bit sum. ADC: s = a+b+cf.
- SUB: s = a-b. SBB: s = a-b-cf. For both, carry = 1 when the unsigned subtrahend plus borrow-in exceeds a (borrow convention).
- V for add: operand signs are equal and the result sign differs. V for sub: operand signs differ and the result sign differs from a.
- Logic ops and PASSB: carry = 0, V = 0, and cf is unchanged.
- cf update: cf <= carry of the accepted op, on the accept edge, for ops 0-3 only. ADC/SBB issued back-to-back use the carry of the immediately preceding accepted arithmetic op.
- Latency: an op accepted at edge t appears on the outputs with out_valid = 1 after edge t+STAGES-1 when there is no stall. STAGES=1 means outputs update on the accept edge. Flags travel with s.
- Stall: stall = out_valid & ~out_ready. On stall, the whole pipeline holds and in_ready = 0. Otherwise in_ready = 1, and each edge shifts every stage, including bubbles (no bubble collapse).
- Throughput: 1 op/cycle while out_ready = 1.
- Outputs hold their value and out_valid stays high until consumed. When out_valid = 0, s and the flags hold their last values (don't care).
- flush (synchronous, highest priority over accept): clears all stage valids and out_valid next edge. Data accepted in the same cycle is discarded and cf is NOT updated. cf is otherwise retained across a flush.
- Wrap-around: results are modulo 2^WIDTH. FFFF+0001 gives s = 0, carry = 1, ZR = 1.
- Reset mid-operation: in-flight entries are lost and outputs return to reset values immediately.

Test Plan:
- WIDTH=16, STAGES=2, ADD a=8fff b=8000 -> 2 cycles later: s=0fff, sn=0, ZR=0, carry=1, P=1, V=1; cf=1.
- ADD fffe+0002 then ADC 0001+0001 back-to-back -> first s=0000, ZR=1, carry=1, P=1, V=0; second s=0003, carry=0, cf=0.
- ADD aaaa+5555 -> s=ffff, sn=1, carry=0, P=1, V=0. Then SUB 8000-0001 -> s=7fff, V=1, carry=0. Then SUB 0000-0001 -> s=ffff, carry=1, sn=1.
- Stream 4 ops with out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall, no op lost or duplicated, results in order, out_valid held.
- Accept SUB 0000-0001 together with flush -> no result emitted, cf unchanged. Also assert rst_n low with 2 ops in flight -> out_valid=0 and all flags 0 immediately; cf=0.
- XOR a=f0f0 b=f0f0 with cf=1 -> s=0000, ZR=1, carry=0, V=0, P=1, cf stays 1. Repeat the arithmetic vectors at WIDTH=8 and STAGES=1 and STAGES=4 -> latency 1 and 4 respectively, flags scaled to the new width.
